// File: rtl/alu.sv
// ALU_def: opcode encoding shared by the ALU and anything that drives it.
//
// alu: 8-bit arithmetic/logic unit for the execute stage.
//   clk        - clock for the status register only
//   rst_n      - asynchronous active-low reset, clears the status register
//   cin        - carry-in, used by ALU_ADDC only
//   ctrl_input - operation select (ALU_def::ALU_CTRL)
//   a, b       - operands; b doubles as the signed shift amount
//   flag_we    - status register write enable
//   out        - combinational result
//   cout       - combinational carry-out (ADD/ADDC only, else 0)
//   zero       - combinational, high when out == 0
//   cout_q     - registered cout
//   zero_q     - registered zero
package ALU_def;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDC = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_LT   = 4'd6,
    ALU_LTS  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_NEG  = 4'd9,
    ALU_AND  = 4'd10
  } ALU_CTRL;
endpackage

module alu (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cin,
  input  ALU_def::ALU_CTRL ctrl_input,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             flag_we,
  output logic [7:0]       out,
  output logic             cout,
  output logic             zero,
  output logic             cout_q,
  output logic             zero_q
);
  import ALU_def::*;

  logic       addCarry;
  logic [8:0] sum9;
  logic       shNeg;
  logic [7:0] shMag;
  logic       shBig;
  logic [2:0] shAmt;
  logic [7:0] shlRes;
  logic [7:0] srlRes;
  logic [7:0] sraRes;
  logic       cout_d;
  logic       zero_d;

  // A negative b reverses the shift direction. The magnitude of -128 is
  // 0x80, which correctly lands in the "shift by 8 or more" bucket.
  assign addCarry = (ctrl_input == ALU_ADDC) & cin;
  assign sum9     = {1'b0, a} + {1'b0, b} + {8'd0, addCarry};
  assign shNeg    = b[7];
  assign shMag    = shNeg ? (~b + 8'd1) : b;
  assign shBig    = |shMag[7:3];
  assign shAmt    = shMag[2:0];
  assign shlRes   = shBig ? 8'h00 : (a << shAmt);
  assign srlRes   = shBig ? 8'h00 : (a >> shAmt);
  assign sraRes   = shBig ? {8{a[7]}} : 8'($signed(a) >>> shAmt);

  always_comb begin
    out  = 8'h00;
    cout = 1'b0;
    case (ctrl_input)
      ALU_ADD,
      ALU_ADDC: {cout, out} = sum9;
      ALU_SUB:  out = a - b;
      ALU_SLL:  out = shNeg ? srlRes : shlRes;
      ALU_SRA:  out = shNeg ? shlRes : sraRes;
      ALU_SRL:  out = shNeg ? shlRes : srlRes;
      ALU_LT:   out = {7'd0, (a < b)};
      ALU_LTS:  out = {7'd0, ($signed(a) < $signed(b))};
      ALU_OR:   out = a | b;
      ALU_NEG:  out = ~a;
      ALU_AND:  out = a & b;
      default:  out = 8'h00;
    endcase
    zero = (out == 8'h00);
  end

  // Status register next-state: capture on flag_we, otherwise hold.
  always_comb begin
    cout_d = cout_q;
    zero_d = zero_q;
    if (flag_we) begin
      cout_d = cout;
      zero_d = zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      cout_q <= cout_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Expected results are pushed onto a
// scoreboard queue as stimulus is applied and popped when the DUT output
// is sampled.
module tb_alu;
  logic             clk;
  logic             rst_n;
  logic             cin;
  logic [3:0]       opSel;
  ALU_def::ALU_CTRL ctrl;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             flag_we;
  logic [7:0]       out;
  logic             cout;
  logic             zero;
  logic             cout_q;
  logic             zero_q;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] out;
    logic       cout;
    logic       zero;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       cout;
    logic       zero;
  } exp_t;

  exp_t sb[$];

  assign ctrl = ALU_def::ALU_CTRL'(opSel);

  alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cin        (cin),
    .ctrl_input (ctrl),
    .a          (a),
    .b          (b),
    .flag_we    (flag_we),
    .out        (out),
    .cout       (cout),
    .zero       (zero),
    .cout_q     (cout_q),
    .zero_q     (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: shifts are done one position at a time so the
  // model shares no structure with the barrel shifter in the design.
  function automatic logic [9:0] model(input logic [3:0] op, input logic [7:0] ia,
                                       input logic [7:0] ib, input logic ic);
    int         s;
    int         m;
    logic [7:0] x;
    logic [7:0] r;
    logic       c;
    logic [8:0] w;
    logic       goLeft;
    logic       arith;
    s = int'($signed(ib));
    m = (s < 0) ? -s : s;
    if (m > 8) m = 8;
    r = 8'h00;
    c = 1'b0;
    goLeft = 1'b0;
    arith  = 1'b0;
    case (op)
      4'd0: begin w = 9'(ia) + 9'(ib); r = w[7:0]; c = w[8]; end
      4'd1: begin w = 9'(ia) + 9'(ib) + 9'(ic); r = w[7:0]; c = w[8]; end
      4'd2: r = 8'((int'(ia) - int'(ib) + 256) % 256);
      4'd3, 4'd4, 4'd5: begin
        if (op == 4'd3) goLeft = (s >= 0);
        else            goLeft = (s < 0);
        arith = (op == 4'd4) && (s >= 0);
        x = ia;
        for (int i = 0; i < m; i++) begin
          if (goLeft)     x = {x[6:0], 1'b0};
          else if (arith) x = {x[7], x[7:1]};
          else            x = {1'b0, x[7:1]};
        end
        r = x;
      end
      4'd6: r = (int'(ia) < int'(ib)) ? 8'd1 : 8'd0;
      4'd7: r = (int'($signed(ia)) < int'($signed(ib))) ? 8'd1 : 8'd0;
      4'd8: r = ia | ib;
      4'd9: r = ~ia;
      4'd10: r = ia & ib;
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), c, r};
  endfunction

  // Drive one combinational operation and record what it should produce.
  task automatic applyStimulus(input vec_t v);
    opSel = v.op;
    a     = v.a;
    b     = v.b;
    cin   = v.cin;
    sb.push_back('{v.name, v.out, v.cout, v.zero});
  endtask

  task automatic runVectors(input vec_t vs[$]);
    exp_t e;
    foreach (vs[i]) begin
      applyStimulus(vs[i]);
      #2;
      e = sb.pop_front();
      total++;
      if ({out, cout, zero} !== {e.out, e.cout, e.zero}) begin
        bad++;
        $display("[TB] FAIL %s: got out=%h cout=%b zero=%b, want out=%h cout=%b zero=%b",
                 e.name, out, cout, zero, e.out, e.cout, e.zero);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cout_q, zero_q} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_async: got cout_q=%b zero_q=%b, want 0 0", cout_q, zero_q);
    end
    opSel = 4'd0; a = 8'hFF; b = 8'h01; cin = 1'b0; flag_we = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cout_q, zero_q} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_hold: got cout_q=%b zero_q=%b, want 0 0", cout_q, zero_q);
    end
    flag_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    vec_t vs[$];
    vs.push_back('{"add_11_23", 4'd0, 8'd11, 8'd23, 1'b1, 8'd34, 1'b0, 1'b0});
    vs.push_back('{"add_255_1", 4'd0, 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1});
    vs.push_back('{"addc_11_23", 4'd1, 8'd11, 8'd23, 1'b1, 8'd35, 1'b0, 1'b0});
    vs.push_back('{"addc_254_1", 4'd1, 8'd254, 8'd1, 1'b1, 8'd0, 1'b1, 1'b1});
    vs.push_back('{"addc_255_255", 4'd1, 8'd255, 8'd255, 1'b1, 8'hFF, 1'b1, 1'b0});
    runVectors(vs);
  endtask

  task automatic test_compare;
    vec_t vs[$];
    vs.push_back('{"sub_0_1", 4'd2, 8'd0, 8'd1, 1'b1, 8'd255, 1'b0, 1'b0});
    vs.push_back('{"sub_1_1", 4'd2, 8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b1});
    vs.push_back('{"lt_255_0", 4'd6, 8'd255, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1});
    vs.push_back('{"lt_0_255", 4'd6, 8'd0, 8'd255, 1'b0, 8'd1, 1'b0, 1'b0});
    vs.push_back('{"lts_m1_0", 4'd7, 8'hFF, 8'h00, 1'b0, 8'd1, 1'b0, 1'b0});
    vs.push_back('{"lts_m18_m17", 4'd7, 8'hEE, 8'hEF, 1'b0, 8'd1, 1'b0, 1'b0});
    vs.push_back('{"lts_m16_m17", 4'd7, 8'hF0, 8'hEF, 1'b0, 8'd0, 1'b0, 1'b1});
    runVectors(vs);
  endtask

  task automatic test_shift;
    vec_t vs[$];
    vs.push_back('{"sll_8_2", 4'd3, 8'd8, 8'd2, 1'b0, 8'd32, 1'b0, 1'b0});
    vs.push_back('{"sll_128_1", 4'd3, 8'd128, 8'd1, 1'b0, 8'd0, 1'b0, 1'b1});
    vs.push_back('{"sll_5_m1", 4'd3, 8'd5, 8'hFF, 1'b0, 8'd2, 1'b0, 1'b0});
    vs.push_back('{"sll_81_m128", 4'd3, 8'h81, 8'h80, 1'b0, 8'd0, 1'b0, 1'b1});
    vs.push_back('{"sra_80_1", 4'd4, 8'h80, 8'd1, 1'b0, 8'hC0, 1'b0, 1'b0});
    vs.push_back('{"sra_ff_m1", 4'd4, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b0});
    vs.push_back('{"sra_80_100", 4'd4, 8'h80, 8'd100, 1'b0, 8'hFF, 1'b0, 1'b0});
    vs.push_back('{"sra_40_3", 4'd4, 8'h40, 8'd3, 1'b0, 8'h08, 1'b0, 1'b0});
    vs.push_back('{"srl_1_m2", 4'd5, 8'd1, 8'hFE, 1'b0, 8'd4, 1'b0, 1'b0});
    vs.push_back('{"srl_80_m1", 4'd5, 8'h80, 8'hFF, 1'b0, 8'd0, 1'b0, 1'b1});
    vs.push_back('{"srl_ff_8", 4'd5, 8'hFF, 8'd8, 1'b0, 8'd0, 1'b0, 1'b1});
    vs.push_back('{"srl_80_7", 4'd5, 8'h80, 8'd7, 1'b0, 8'd1, 1'b0, 1'b0});
    vs.push_back('{"srl_a5_0", 4'd5, 8'hA5, 8'd0, 1'b0, 8'hA5, 1'b0, 1'b0});
    runVectors(vs);
  endtask

  task automatic test_logic;
    vec_t vs[$];
    vs.push_back('{"or_55_aa", 4'd8, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0});
    vs.push_back('{"and_55_aa", 4'd10, 8'h55, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1});
    vs.push_back('{"neg_55", 4'd9, 8'h55, 8'hF0, 1'b0, 8'hAA, 1'b0, 1'b0});
    vs.push_back('{"neg_ff", 4'd9, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});
    vs.push_back('{"op12", 4'd12, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1});
    vs.push_back('{"op15", 4'd15, 8'h7F, 8'h01, 1'b1, 8'h00, 1'b0, 1'b1});
    runVectors(vs);
  endtask

  task automatic test_random;
    vec_t vs[$];
    logic [9:0] m;
    vec_t v;
    for (int i = 0; i < 60; i++) begin
      v.name = $sformatf("rand_%0d", i);
      v.op   = 4'($urandom_range(0, 15));
      v.a    = 8'($urandom);
      v.b    = 8'($urandom);
      v.cin  = 1'($urandom);
      m      = model(v.op, v.a, v.b, v.cin);
      v.out  = m[7:0];
      v.cout = m[8];
      v.zero = m[9];
      vs.push_back(v);
    end
    runVectors(vs);
  endtask

  task automatic test_status;
    @(negedge clk);
    opSel = 4'd0; a = 8'd255; b = 8'd1; cin = 1'b0; flag_we = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cout_q, zero_q} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL status_capture: got cout_q=%b zero_q=%b, want 1 1", cout_q, zero_q);
    end
    @(negedge clk);
    a = 8'd1; b = 8'd1; flag_we = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cout_q, zero_q} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL status_hold: got cout_q=%b zero_q=%b, want 1 1", cout_q, zero_q);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cout_q, zero_q} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL status_midreset: got cout_q=%b zero_q=%b, want 0 0", cout_q, zero_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'd255; b = 8'd1; flag_we = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cout_q, zero_q} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL status_after_release: got cout_q=%b zero_q=%b, want 1 1", cout_q, zero_q);
    end
    flag_we = 1'b0;
  endtask

  // One new operation per cycle; the expected registered flags for each
  // edge go onto the scoreboard when the operation is driven.
  task automatic test_back_to_back;
    logic [9:0] m;
    logic       mc;
    logic       mz;
    exp_t       e;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mc = 1'b0;
    mz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      opSel   = (i % 3 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      a       = (i % 5 == 0) ? 8'hFF : 8'($urandom);
      b       = (i % 5 == 0) ? 8'h01 : 8'($urandom);
      cin     = 1'($urandom);
      flag_we = (i % 4 != 3);
      m = model(opSel, a, b, cin);
      if (flag_we) begin
        mc = m[8];
        mz = m[9];
      end
      sb.push_back('{$sformatf("b2b_%0d", i), 8'h00, mc, mz});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if ({cout_q, zero_q} !== {e.cout, e.zero}) begin
        bad++;
        $display("[TB] FAIL %s: got cout_q=%b zero_q=%b, want %b %b",
                 e.name, cout_q, zero_q, e.cout, e.zero);
      end
    end
    flag_we = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b1;
    cin     = 1'b0;
    opSel   = 4'd0;
    a       = 8'd0;
    b       = 8'd0;
    flag_we = 1'b0;
    #1;
    test_reset;
    test_add;
    test_compare;
    test_shift;
    test_logic;
    test_random;
    test_status;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
